// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM controller: mode encodings
// and default parameter values.
package pwm_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    localparam int W_DEFAULT         = 8;
    localparam int STEP_DEFAULT      = 16;
    localparam int DB_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-flop synchroniser, stability counter and a one-clock
// pulse on each accepted press.
module key_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          meta;
    logic          sync;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;

    // Synchroniser presets high so a key held through reset reads as pressed
    // and cannot arm the debouncer until it has been seen released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= key;
            sync <= meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (!armed) begin
                armed <= !sync;
                cnt   <= '0;
            end else if (sync != level) begin
                if (cnt == CW'(DB_CYCLES - 1)) begin
                    level <= sync;
                    cnt   <= '0;
                    pulse <= sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/multi_pwm_controller.sv
// Multi-channel PWM generator with key-driven duty programming, shared
// edge/center-aligned counter and period-boundary shadow loading.
module multi_pwm_controller
    import pwm_pkg::*;
#(
    parameter int CH        = 4,
    parameter int W         = W_DEFAULT,
    parameter int STEP      = STEP_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_up,
    input  logic                  key_down,
    input  logic                  key_sel,
    input  logic                  mode,
    output logic [CH-1:0]         pwm_out,
    output logic [$clog2(CH)-1:0] sel_ch,
    output logic [W-1:0]          duty_sel
);

    localparam int            SW      = $clog2(CH);
    localparam logic [W-1:0]  CNT_MAX = '1;

    logic          up_pulse;
    logic          down_pulse;
    logic          sel_pulse;
    logic [W-1:0]  duty_p [CH];
    logic [W-1:0]  duty_a [CH];
    logic [W-1:0]  cnt;
    logic          dir;
    pwm_mode_e     mode_s;
    logic          boundary;
    logic [W-1:0]  thr;
    logic [CH-1:0] pwm_next;

    function automatic logic [W-1:0] sat_up(input logic [W-1:0] d);
        logic [W:0] s;
        s = {1'b0, d} + (W+1)'(STEP);
        return s[W] ? CNT_MAX : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sat_down(input logic [W-1:0] d);
        if ({1'b0, d} < (W+1)'(STEP))
            return '0;
        return d - W'(STEP);
    endfunction

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk(clk), .rst(rst), .key(key_up), .pulse(up_pulse)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clk(clk), .rst(rst), .key(key_down), .pulse(down_pulse)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
        .clk(clk), .rst(rst), .key(key_sel), .pulse(sel_pulse)
    );

    // Duty change uses the pre-increment channel when sel coincides.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_ch <= '0;
            for (int i = 0; i < CH; i++)
                duty_p[i] <= '0;
        end else begin
            if (up_pulse && !down_pulse)
                duty_p[sel_ch] <= sat_up(duty_p[sel_ch]);
            else if (down_pulse && !up_pulse)
                duty_p[sel_ch] <= sat_down(duty_p[sel_ch]);
            if (sel_pulse)
                sel_ch <= (sel_ch == SW'(CH - 1)) ? '0 : sel_ch + 1'b1;
        end
    end

    assign duty_sel = duty_p[sel_ch];
    assign boundary = (cnt == '0) && !dir;

    // Center mode runs 0..MAX then MAX-1..1, so cnt==0 occurs once per period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            dir    <= 1'b0;
            mode_s <= MODE_EDGE;
        end else begin
            if (boundary)
                mode_s <= pwm_mode_e'(mode);
            if (mode_s == MODE_EDGE) begin
                cnt <= cnt + 1'b1;
            end else if (!dir) begin
                if (cnt == CNT_MAX) begin
                    dir <= 1'b1;
                    cnt <= CNT_MAX - 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (cnt == W'(1)) begin
                dir <= 1'b0;
                cnt <= '0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++)
                duty_a[i] <= '0;
        end else if (boundary) begin
            for (int i = 0; i < CH; i++)
                duty_a[i] <= duty_p[i];
        end
    end

    // The boundary cycle compares against the value being loaded so the new
    // duty starts cleanly. Down phase uses <= giving 2*duty high clocks.
    always_comb begin
        pwm_next = '0;
        thr      = '0;
        for (int i = 0; i < CH; i++) begin
            thr         = boundary ? duty_p[i] : duty_a[i];
            pwm_next[i] = dir ? (cnt <= thr) : (cnt < thr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pwm_out <= '0;
        else
            pwm_out <= pwm_next;
    end

endmodule
